// File: rtl/xadac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadac_pkg : shared widths and types for the xadac vector stages   (rev 1.0)
// ---------------------------------------------------------------------------
package xadac_pkg;

  localparam int SUM_WIDTH  = 32;
  localparam int ELEM_WIDTH = 8;
  localparam int VEC_WIDTH  = 256;
  localparam int NUM_LANES  = VEC_WIDTH / SUM_WIDTH;
  localparam int CNT_WIDTH  = $clog2(NUM_LANES + 1);
  localparam int PACK_WIDTH = ELEM_WIDTH * NUM_LANES;

  typedef logic signed [SUM_WIDTH-1:0] sum_t;
  // One guard bit so the rounding bias can never wrap a positive lane negative.
  typedef logic signed [SUM_WIDTH:0]   sum_ext_t;
  typedef logic signed [ELEM_WIDTH-1:0] elem_t;

  typedef struct packed {
    logic       relu_en;
    logic [4:0] shift;
  } quant_ctrl_t;

  function automatic logic [CNT_WIDTH-1:0] lane_count(input logic [31:0] imm);
    if (imm > 32'(NUM_LANES)) begin
      return CNT_WIDTH'(NUM_LANES);
    end
    return CNT_WIDTH'(imm);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xadac_quant_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadac_quant_lane : single-lane round/shift (rnd) and relu/saturate (elem) (rev 1.0)
// ---------------------------------------------------------------------------
module xadac_quant_lane
  import xadac_pkg::*;
(
  input  sum_t       x,
  input  logic [4:0] shift,
  output sum_ext_t   rnd,
  input  sum_ext_t   t,
  input  logic       relu_en,
  output elem_t      elem
);

  localparam sum_ext_t c_max = sum_ext_t'((1 << (ELEM_WIDTH - 1)) - 1);
  localparam sum_ext_t c_min = ~c_max;

  sum_ext_t w_bias;
  sum_ext_t w_sum;
  sum_ext_t w_relu;

  always_comb begin
    w_bias = '0;
    if (shift != 5'd0) begin
      w_bias = sum_ext_t'(1) << (shift - 5'd1);
    end
    w_sum = {x[SUM_WIDTH-1], x} + w_bias;
    rnd   = w_sum >>> shift;
  end

  always_comb begin
    w_relu = (relu_en && t[SUM_WIDTH]) ? '0 : t;
    if (w_relu > c_max) begin
      elem = c_max[ELEM_WIDTH-1:0];
    end else if (w_relu < c_min) begin
      elem = c_min[ELEM_WIDTH-1:0];
    end else begin
      elem = w_relu[ELEM_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/xadac_stage_vquant.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadac_stage_vquant : two-register elastic requantisation stage, SumT -> ElemT (rev 1.0)
// ---------------------------------------------------------------------------
module xadac_stage_vquant
  import xadac_pkg::*;
#(
  parameter int ID_WIDTH  = 8,
  parameter int XLEN      = 32,
  parameter int IMM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic [VEC_WIDTH-1:0] req_vs1,
  input  logic [XLEN-1:0]      req_rs1,
  input  logic [IMM_WIDTH-1:0] req_imm,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_WIDTH-1:0]  resp_id,
  output logic [VEC_WIDTH-1:0] resp_vd,
  output logic [XLEN-1:0]      resp_rd
);

  quant_ctrl_t          w_ctrl;
  logic                 w_unused_rs1;
  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_accept;
  logic                 w_adv2;
  sum_ext_t             w_rnd  [NUM_LANES];
  elem_t                w_elem [NUM_LANES];
  logic [PACK_WIDTH-1:0] w_vd;

  // Stage 1: rounded/shifted lanes plus the controls stage 2 still needs.
  logic                 r1_valid;
  logic [ID_WIDTH-1:0]  r1_id;
  logic [CNT_WIDTH-1:0] r1_count;
  logic                 r1_relu;
  sum_ext_t             r1_t [NUM_LANES];

  // Stage 2: packed result, sole source of the response outputs.
  logic                  r2_valid;
  logic [ID_WIDTH-1:0]   r2_id;
  logic [PACK_WIDTH-1:0] r2_vd;

  assign w_ctrl       = quant_ctrl_t'(req_rs1[5:0]);
  assign w_unused_rs1 = ^req_rs1[XLEN-1:6];
  assign w_count      = lane_count(32'(req_imm));

  // Ready depends only on stage state and resp_ready, never on req_valid.
  assign w_adv2    = r1_valid && (!r2_valid || resp_ready);
  assign req_ready = !r1_valid || w_adv2;
  assign w_accept  = req_valid && req_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    xadac_quant_lane u_lane (
      .x       (req_vs1[SUM_WIDTH*i +: SUM_WIDTH]),
      .shift   (w_ctrl.shift),
      .rnd     (w_rnd[i]),
      .t       (r1_t[i]),
      .relu_en (r1_relu),
      .elem    (w_elem[i])
    );
    assign w_vd[ELEM_WIDTH*i +: ELEM_WIDTH] =
      (CNT_WIDTH'(i) < r1_count) ? w_elem[i] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_valid <= 1'b0;
      r1_id    <= '0;
      r1_count <= '0;
      r1_relu  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r1_t[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r1_valid <= 1'b1;
        r1_id    <= req_id;
        r1_count <= w_count;
        r1_relu  <= w_ctrl.relu_en;
        for (int k = 0; k < NUM_LANES; k++) begin
          r1_t[k] <= w_rnd[k];
        end
      end else if (w_adv2) begin
        r1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_valid <= 1'b0;
      r2_id    <= '0;
      r2_vd    <= '0;
    end else begin
      if (w_adv2) begin
        r2_valid <= 1'b1;
        r2_id    <= r1_id;
        r2_vd    <= w_vd;
      end else if (resp_ready) begin
        r2_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r2_valid;
  assign resp_id    = r2_id;
  assign resp_vd    = VEC_WIDTH'(r2_vd);
  assign resp_rd    = '0;

endmodule
`default_nettype wire
